// File: rtl/bram_tdp_lane.sv
// bram_tdp_lane: true dual-port RAM with per-lane write enables and a
// power-on clear sweep.
//
// Parameters
//   DW  data word width (bits)          WL  depth in words (>= 2)
//   LW  write-lane width (DW % LW == 0)  RL  read latency, 1 or 2 cycles
//   NL = DW / LW lanes,                 AW = clog2(WL) address bits
//
// Ports
//   CLK, RST             single clock, synchronous active-high reset
//   BUSY                 clear sweep running; both ports ignore EN
//   ENx, WEx, Ax, Dix    port x request, lane write enables, address, data
//   Dox, VLDx            port x read data and its one-cycle valid strobe
//
// Every accepted access is a read (read-first); lanes with WE set are also
// written. Same-address, same-lane writes from both ports resolve to port A.
// Out-of-range addresses drop the write and read back zero.
//
// Optional feature: define BRAM_TDP_BYPASS_EN to make a read on one port
// return the merged new word when the other port writes that address in the
// same cycle. Without it, cross-port reads see the old word.

module bram_tdp_lane #(
  parameter int unsigned DW = 128,
  parameter int unsigned WL = 128,
  parameter int unsigned LW = 32,
  parameter int unsigned RL = 1,
  localparam int unsigned NL = DW / LW,
  localparam int unsigned AW = $clog2(WL)
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          BUSY,
  // Port A
  input  logic          ENA,
  input  logic [NL-1:0] WEA,
  input  logic [AW-1:0] AA,
  input  logic [DW-1:0] DiA,
  output logic [DW-1:0] DoA,
  output logic          VLDA,
  // Port B
  input  logic          ENB,
  input  logic [NL-1:0] WEB,
  input  logic [AW-1:0] AB,
  input  logic [DW-1:0] DiB,
  output logic [DW-1:0] DoB,
  output logic          VLDB
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  localparam logic [AW:0]   WlLimit = (AW + 1)'(WL);
  localparam logic [AW-1:0] LastWord = AW'(WL - 1);

  // ---------------------------------------------------------------------------
  // Clear sweep
  // ---------------------------------------------------------------------------
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (state_q == StClear) begin
      clr_we = 1'b1;
      if (cnt_q == LastWord) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // BUSY is held low while RST is high so it rises on the first cycle after
  // RST falls and stays high for exactly WL sweep cycles.
  assign BUSY = (state_q == StClear) && !RST;

  // ---------------------------------------------------------------------------
  // Access acceptance
  // ---------------------------------------------------------------------------
  logic acc_a, acc_b;
  logic in_a, in_b;
  logic wr_a, wr_b;

  always_comb begin
    acc_a = ENA && !BUSY && !RST;
    acc_b = ENB && !BUSY && !RST;
    in_a  = {1'b0, AA} < WlLimit;
    in_b  = {1'b0, AB} < WlLimit;
    wr_a  = acc_a && in_a;
    wr_b  = acc_b && in_b;
  end

  // ---------------------------------------------------------------------------
  // Storage array. Held without reset; the clear sweep zeroes it instead.
  // Port B is written first so a lane written by both ports ends with A.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem_q [WL];

  always_ff @(posedge CLK) begin
    if (clr_we && !RST) begin
      mem_q[cnt_q] <= '0;
    end
    for (int i = 0; i < int'(NL); i++) begin
      if (wr_b && WEB[i]) begin
        mem_q[AB][i*LW +: LW] <= DiB[i*LW +: LW];
      end
      if (wr_a && WEA[i]) begin
        mem_q[AA][i*LW +: LW] <= DiA[i*LW +: LW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Array read (read-first: the pre-write contents)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] old_a, old_b;
  logic [DW-1:0] rd_a, rd_b;

  always_comb begin
    old_a = in_a ? mem_q[AA] : '0;
    old_b = in_b ? mem_q[AB] : '0;
  end

`ifdef BRAM_TDP_BYPASS_EN
  // Cross-port bypass: when the other port writes the address being read, the
  // reader sees the word as it will stand after this cycle, A winning shared
  // lanes. A port's own write alone never bypasses (read-first).
  logic          same_addr;
  logic          hit_a, hit_b;
  logic [DW-1:0] merged;

  always_comb begin
    same_addr = wr_a && wr_b && (AA == AB);
    hit_a     = same_addr && (|WEB);
    hit_b     = same_addr && (|WEA);
    merged    = old_a;
    for (int i = 0; i < int'(NL); i++) begin
      if (WEB[i]) begin
        merged[i*LW +: LW] = DiB[i*LW +: LW];
      end
      if (WEA[i]) begin
        merged[i*LW +: LW] = DiA[i*LW +: LW];
      end
    end
    rd_a = hit_a ? merged : old_a;
    rd_b = hit_b ? merged : old_b;
  end
`else
  always_comb begin
    rd_a = old_a;
    rd_b = old_b;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output stage 1: array read register. Data only moves on an accepted
  // access, so Do holds between strobes.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] do_a1_q, do_a1_d, do_b1_q, do_b1_d;
  logic          vld_a1_q, vld_a1_d, vld_b1_q, vld_b1_d;

  always_comb begin
    vld_a1_d = acc_a;
    vld_b1_d = acc_b;
    do_a1_d  = acc_a ? rd_a : do_a1_q;
    do_b1_d  = acc_b ? rd_b : do_b1_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      do_a1_q  <= '0;
      do_b1_q  <= '0;
      vld_a1_q <= 1'b0;
      vld_b1_q <= 1'b0;
    end else begin
      do_a1_q  <= do_a1_d;
      do_b1_q  <= do_b1_d;
      vld_a1_q <= vld_a1_d;
      vld_b1_q <= vld_b1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output stage 2 (RL == 2): data and valid shift together.
  // ---------------------------------------------------------------------------
  if (RL == 2) begin : g_rl2
    logic [DW-1:0] do_a2_q, do_a2_d, do_b2_q, do_b2_d;
    logic          vld_a2_q, vld_a2_d, vld_b2_q, vld_b2_d;

    always_comb begin
      vld_a2_d = vld_a1_q;
      vld_b2_d = vld_b1_q;
      do_a2_d  = vld_a1_q ? do_a1_q : do_a2_q;
      do_b2_d  = vld_b1_q ? do_b1_q : do_b2_q;
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        do_a2_q  <= '0;
        do_b2_q  <= '0;
        vld_a2_q <= 1'b0;
        vld_b2_q <= 1'b0;
      end else begin
        do_a2_q  <= do_a2_d;
        do_b2_q  <= do_b2_d;
        vld_a2_q <= vld_a2_d;
        vld_b2_q <= vld_b2_d;
      end
    end

    assign DoA  = do_a2_q;
    assign DoB  = do_b2_q;
    assign VLDA = vld_a2_q;
    assign VLDB = vld_b2_q;
  end else begin : g_rl1
    assign DoA  = do_a1_q;
    assign DoB  = do_b1_q;
    assign VLDA = vld_a1_q;
    assign VLDB = vld_b1_q;
  end

endmodule

// File: tb/tb_bram_tdp_lane.sv
// Bench for bram_tdp_lane: two instances (WL=128/RL=1 and WL=100/RL=2),
// a word-array reference model, and a per-port scoreboard drained by a
// negedge monitor.

module tb_bram_tdp_lane;

  localparam int DW  = 128;
  localparam int LW  = 32;
  localparam int NL  = 4;
  localparam int AW  = 7;
  localparam int WL0 = 128;
  localparam int WL1 = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst  [2];
  logic          busy [2];
  logic          ena  [2], enb [2];
  logic [NL-1:0] wea  [2], web [2];
  logic [AW-1:0] aa   [2], ab  [2];
  logic [DW-1:0] dia  [2], dib [2];
  logic [DW-1:0] doa  [2], dob [2];
  logic          vlda [2], vldb [2];

  bram_tdp_lane #(.DW(DW), .WL(WL0), .LW(LW), .RL(1)) u_dut0 (
    .CLK(clk), .RST(rst[0]), .BUSY(busy[0]),
    .ENA(ena[0]), .WEA(wea[0]), .AA(aa[0]), .DiA(dia[0]), .DoA(doa[0]), .VLDA(vlda[0]),
    .ENB(enb[0]), .WEB(web[0]), .AB(ab[0]), .DiB(dib[0]), .DoB(dob[0]), .VLDB(vldb[0])
  );

  bram_tdp_lane #(.DW(DW), .WL(WL1), .LW(LW), .RL(2)) u_dut1 (
    .CLK(clk), .RST(rst[1]), .BUSY(busy[1]),
    .ENA(ena[1]), .WEA(wea[1]), .AA(aa[1]), .DiA(dia[1]), .DoA(doa[1]), .VLDA(vlda[1]),
    .ENB(enb[1]), .WEB(web[1]), .AB(ab[1]), .DiB(dib[1]), .DoB(dob[1]), .VLDB(vldb[1])
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  // Scoreboard index: 2*dut + port (0 = A, 1 = B)
  exp_t          q     [4][$];
  logic [DW-1:0] last  [4];
  logic [DW-1:0] mem_m [2][128];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  bit            mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wl_of(input int d);
    return (d == 0) ? WL0 : WL1;
  endfunction

  function automatic int rl_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic check_port(input int p, input logic v, input logic [DW-1:0] o);
    exp_t e;
    total++;
    if (v === 1'b1) begin
      if (q[p].size() == 0) begin
        bad++;
        $display("FAIL port%0d unexpected_vld: got data=%h with nothing outstanding at cycle %0d",
                 p, o, cyc);
      end else begin
        e = q[p].pop_front();
        last[p] = e.data;
        if (o !== e.data || e.due != cyc) begin
          bad++;
          $display("FAIL port%0d read: got %h at cycle %0d, want %h at cycle %0d",
                   p, o, cyc, e.data, e.due);
        end
      end
    end else if (q[p].size() != 0 && q[p][0].due <= cyc) begin
      bad++;
      $display("FAIL port%0d missing_vld: vld=%b at cycle %0d, want data %h", p, v, cyc,
               q[p][0].data);
      e = q[p].pop_front();
      last[p] = e.data;
    end else if (o !== last[p]) begin
      bad++;
      $display("FAIL port%0d hold: got %h, want %h at cycle %0d", p, o, last[p], cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check_port(0, vlda[0], doa[0]);
      check_port(1, vldb[0], dob[0]);
      check_port(2, vlda[1], doa[1]);
      check_port(3, vldb[1], dob[1]);
    end
  end

  // ---------------------------------------------------------------------------
  // One clock of stimulus on dut d, with the model updated when not busy.
  // ---------------------------------------------------------------------------
  task automatic step(input int d,
                      input bit ea, input logic [NL-1:0] wa, input logic [AW-1:0] a_a,
                      input logic [DW-1:0] da,
                      input bit eb, input logic [NL-1:0] wb, input logic [AW-1:0] a_b,
                      input logic [DW-1:0] db,
                      input bit busy_m);
    int            wl;
    bit            ina, inb;
    logic [DW-1:0] rda, rdb;
    exp_t          e;
    wl  = wl_of(d);
    ina = int'(a_a) < wl;
    inb = int'(a_b) < wl;
    ena[d] = ea; wea[d] = wa; aa[d] = a_a; dia[d] = da;
    enb[d] = eb; web[d] = wb; ab[d] = a_b; dib[d] = db;
    if (!busy_m) begin
      rda = (ea && ina) ? mem_m[d][a_a] : '0;
      rdb = (eb && inb) ? mem_m[d][a_b] : '0;
      for (int i = 0; i < NL; i++) begin
        if (eb && inb && wb[i]) mem_m[d][a_b][i*LW +: LW] = db[i*LW +: LW];
      end
      for (int i = 0; i < NL; i++) begin
        if (ea && ina && wa[i]) mem_m[d][a_a][i*LW +: LW] = da[i*LW +: LW];
      end
`ifdef BRAM_TDP_BYPASS_EN
      if (ea && eb && ina && inb && a_a == a_b) begin
        if (wb != '0) rda = mem_m[d][a_a];
        if (wa != '0) rdb = mem_m[d][a_b];
      end
`endif
      if (ea) begin
        e.data = rda; e.due = cyc + rl_of(d);
        q[2*d].push_back(e);
      end
      if (eb) begin
        e.data = rdb; e.due = cyc + rl_of(d);
        q[2*d+1].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 0, '0, '0, '0, 0, '0, '0, '0, 0);
  endtask

  task automatic rand_step(input int d, input bit busy_m);
    logic [AW-1:0] a1, a2;
    a1 = ($urandom() % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
    a2 = ($urandom() % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
    step(d, ($urandom() % 4) != 0, NL'($urandom()), a1, rnd_word(),
         ($urandom() % 4) != 0, NL'($urandom()), a2, rnd_word(), busy_m);
  endtask

  // ---------------------------------------------------------------------------
  // Reset pulse and clear sweep
  // ---------------------------------------------------------------------------
  task automatic pulse(input int d);
    ena[d] = 0; enb[d] = 0; rst[d] = 1'b1;
    @(posedge clk);
    #1;
    // In-flight reads are discarded by the reset edge
    q[2*d].delete(); q[2*d+1].delete();
    last[2*d] = '0; last[2*d+1] = '0;
    for (int a = 0; a < 128; a++) mem_m[d][a] = '0;
    total++;
    if (busy[d] !== 1'b0 || vlda[d] !== 1'b0 || vldb[d] !== 1'b0) begin
      bad++;
      $display("FAIL dut%0d reset_outputs: busy=%b vlda=%b vldb=%b, want 0 0 0",
               d, busy[d], vlda[d], vldb[d]);
    end
    rst[d] = 1'b0;
    #1;
  endtask

  // n busy cycles, hammering both ports to show they are ignored
  task automatic sweep(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      total++;
      if (busy[d] !== 1'b1) begin
        bad++;
        $display("FAIL dut%0d busy_sweep: busy=%b at sweep cycle %0d, want 1", d, busy[d], i);
      end
      rand_step(d, 1'b1);
    end
    ena[d] = 0; enb[d] = 0;
  endtask

  task automatic rst_seq(input int d, input int abort_n);
    pulse(d);
    if (abort_n > 0) begin
      sweep(d, abort_n);
      pulse(d);
    end
    sweep(d, wl_of(d));
    total++;
    if (busy[d] !== 1'b0) begin
      bad++;
      $display("FAIL dut%0d busy_end: busy=%b after %0d cycles, want 0", d, busy[d], wl_of(d));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] w;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ena[d] = 0; enb[d] = 0; wea[d] = '0; web[d] = '0;
      aa[d] = '0; ab[d] = '0; dia[d] = '0; dib[d] = '0;
    end
    for (int p = 0; p < 4; p++) last[p] = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;

    // Clear sweep on dut0, then read every word back from both ports
    rst_seq(0, 0);
    for (int a = 0; a < WL0; a++) begin
      step(0, 1, '0, AW'(a), rnd_word(), 1, '0, AW'((a + 64) % WL0), rnd_word(), 0);
    end
    idle(0, 2);

    // Lane write then cross-port read
    w = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    step(0, 1, 4'b1111, 7'd5, w, 0, '0, '0, '0, 0);
    step(0, 1, 4'b0101, 7'd5, {DW{1'b1}}, 0, '0, '0, '0, 0);
    step(0, 0, '0, '0, '0, 1, 4'b0000, 7'd5, '0, 0);
    idle(0, 2);

    // Same-address collisions
    step(0, 1, 4'b1111, 7'd9, {16{8'hAA}}, 1, 4'b1111, 7'd9, {16{8'hBB}}, 0);
    step(0, 1, 4'b0000, 7'd9, '0, 0, '0, '0, '0, 0);
    step(0, 1, 4'b0011, 7'd9, {16{8'h5A}}, 1, 4'b1100, 7'd9, {16{8'hC3}}, 0);
    step(0, 0, '0, '0, '0, 1, 4'b0000, 7'd9, '0, 0);
    idle(0, 2);

    // Cross-port read during write to a zero word
    step(0, 1, 4'b1111, 7'd3, DW'(16'h1234), 1, 4'b0000, 7'd3, '0, 0);
    step(0, 0, '0, '0, '0, 1, 4'b0000, 7'd3, '0, 0);
    idle(0, 2);

    for (int i = 0; i < 300; i++) rand_step(0, 1'b0);
    idle(0, 3);

    // dut1: sweep restarted part-way through
    rst_seq(1, 37);

    // Streaming on the RL=2 instance plus an out-of-range address
    for (int a = 0; a < 16; a++) step(1, 1, 4'b1111, AW'(a), rnd_word(), 0, '0, '0, '0, 0);
    step(1, 1, 4'b1111, 7'd120, rnd_word(), 0, '0, '0, '0, 0);
    for (int a = 0; a < 16; a++) step(1, 1, 4'b0000, AW'(a), '0, 0, '0, '0, '0, 0);
    step(1, 1, 4'b0000, 7'd120, '0, 1, 4'b0000, 7'd99, '0, 0);
    idle(1, 3);

    for (int i = 0; i < 300; i++) rand_step(1, 1'b0);

    // Access in flight when reset arrives must never produce a strobe
    step(1, 1, 4'b0000, 7'd4, '0, 1, 4'b0000, 7'd7, '0, 0);
    rst_seq(1, 0);
    step(1, 1, 4'b0000, 7'd4, '0, 0, '0, '0, '0, 0);
    idle(1, 6);
    idle(0, 2);

    for (int p = 0; p < 4; p++) begin
      total++;
      if (q[p].size() != 0) begin
        bad++;
        $display("FAIL port%0d drain: %0d reads outstanding, want 0", p, q[p].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
